// File: rtl/vga_pkg.sv
// Shared screen geometry defaults, FSM state encoding and pipeline tag layout
// for the pixel plot stage.
package vga_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int ADDR_W_DEF   = 15;
  localparam int COLOUR_W_DEF = 3;

  localparam int PIX_X_W      = 8;
  localparam int PIX_Y_W      = 7;
  localparam int PLOT_CNT_W   = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } plot_state_t;

  // valid must stay the MSB: the delay line reports occupancy from the top bit
  typedef struct packed {
    logic               valid;
    logic               in_bounds;
    logic [PIX_X_W-1:0] x;
    logic [PIX_Y_W-1:0] y;
  } plot_tag_t;

  localparam int TAG_W = $bits(plot_tag_t);

endpackage

// File: rtl/plot_delay_line.sv
// Fixed-depth shift register carrying pixel tags alongside the framebuffer read.
// The MSB of each word is a valid flag; occupied_o is set while any stage holds one.
module plot_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             occupied_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

  always_comb begin
    occupied_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied_o = occupied_o | stage_q[i][WIDTH-1];
    end
  end

endmodule

// File: rtl/pixel_plot_stage.sv
// Framebuffer-to-VGA plot stage: reads one colour per scanned pixel and emits a
// registered plot strobe. Optional colour keying under PIXEL_PLOT_TRANSPARENT_EN.
//
// state    | meaning
// IDLE     | waiting for start, pipeline empty
// RUN      | accepting scanner pixels
// DRAIN    | last pixel accepted, flushing in-flight reads
// DONE     | one-cycle frame_done pulse
module pixel_plot_stage
  import vga_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int MEM_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [8:0]            in_x,
  input  logic [8:0]            in_y,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [COLOUR_W-1:0]   mem_rdata,
`ifdef PIXEL_PLOT_TRANSPARENT_EN
  input  logic [COLOUR_W-1:0]   key_colour,
`endif
  output logic [PIX_X_W-1:0]    vga_x,
  output logic [PIX_Y_W-1:0]    vga_y,
  output logic [COLOUR_W-1:0]   vga_colour,
  output logic                  vga_plot,
  output logic                  busy,
  output logic                  frame_done,
  output logic [PLOT_CNT_W-1:0] plot_count
);

  localparam logic [8:0]            X_LIM   = 9'(SCREEN_W);
  localparam logic [8:0]            Y_LIM   = 9'(SCREEN_H);
  localparam logic [PLOT_CNT_W-1:0] CNT_MAX = '1;

  plot_state_t state_q, state_d;

  logic                  accept;
  logic                  pipe_occupied;
  logic                  plot_d;
  plot_tag_t             tag_in, tag_out;
  logic [TAG_W-1:0]      tag_out_bits;

  logic                  vga_plot_q;
  logic [PIX_X_W-1:0]    vga_x_q, vga_x_d;
  logic [PIX_Y_W-1:0]    vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
  logic [PLOT_CNT_W-1:0] cnt_q, cnt_d;

  assign accept   = in_valid && (state_q == ST_RUN);
  assign mem_addr = in_addr;

  always_comb begin
    tag_in.valid     = accept;
    tag_in.in_bounds = (in_x < X_LIM) && (in_y < Y_LIM);
    tag_in.x         = in_x[PIX_X_W-1:0];
    tag_in.y         = in_y[PIX_Y_W-1:0];
  end

  plot_delay_line #(
    .DEPTH (MEM_LAT),
    .WIDTH (TAG_W)
  ) u_delay (
    .clk        (clk),
    .resetn     (resetn),
    .d_i        (tag_in),
    .q_o        (tag_out_bits),
    .occupied_o (pipe_occupied)
  );

  assign tag_out = plot_tag_t'(tag_out_bits);

  // The tail of the delay line lines up with mem_rdata for the same pixel.
`ifdef PIXEL_PLOT_TRANSPARENT_EN
  assign plot_d = tag_out.valid && tag_out.in_bounds && (mem_rdata != key_colour);
`else
  assign plot_d = tag_out.valid && tag_out.in_bounds;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!pipe_occupied) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    cnt_d        = cnt_q;
    if (plot_d) begin
      vga_x_d      = tag_out.x;
      vga_y_d      = tag_out.y;
      vga_colour_d = mem_rdata;
    end
    if ((state_q == ST_IDLE) && start) begin
      cnt_d = '0;
    end else if (plot_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      vga_plot_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      vga_plot_q   <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign vga_plot   = vga_plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot_count = cnt_q;

endmodule

// File: tb/tb_pixel_plot_stage.sv
// Directed bench for pixel_plot_stage: table of cycle vectors on a MEM_LAT=1
// instance, plus reset, keying and full-frame MEM_LAT=2 sequences.
module tb_pixel_plot_stage;

  localparam int AW = 15;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic          start, in_valid, in_last, in_ready;
  logic [AW-1:0] in_addr, mem_addr;
  logic [8:0]    in_x, in_y;
  logic [CW-1:0] mem_rdata, key_colour, vga_colour;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic          vga_plot, busy, frame_done;
  logic [14:0]   plot_count;

  logic          start2, in_valid2, in_last2, in_ready2;
  logic [AW-1:0] in_addr2, mem_addr2;
  logic [8:0]    in_x2, in_y2;
  logic [CW-1:0] mem_rdata2, m2_s1, key_colour2, vga_colour2;
  logic [7:0]    vga_x2;
  logic [6:0]    vga_y2;
  logic          vga_plot2, busy2, frame_done2;
  logic [14:0]   plot_count2;

  pixel_plot_stage #(.MEM_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid),
    .in_addr(in_addr), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
`ifdef PIXEL_PLOT_TRANSPARENT_EN
    .key_colour(key_colour),
`endif
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .frame_done(frame_done), .plot_count(plot_count)
  );

  pixel_plot_stage #(.MEM_LAT(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .in_valid(in_valid2),
    .in_addr(in_addr2), .in_x(in_x2), .in_y(in_y2), .in_last(in_last2),
    .in_ready(in_ready2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
`ifdef PIXEL_PLOT_TRANSPARENT_EN
    .key_colour(key_colour2),
`endif
    .vga_x(vga_x2), .vga_y(vga_y2), .vga_colour(vga_colour2), .vga_plot(vga_plot2),
    .busy(busy2), .frame_done(frame_done2), .plot_count(plot_count2)
  );

  // framebuffer contents: colour = (addr + 5) mod 8
  function automatic logic [CW-1:0] colour_of(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a + 15'd5;
    return s[CW-1:0];
  endfunction

  always @(posedge clk) mem_rdata <= colour_of(mem_addr);
  always @(posedge clk) begin
    m2_s1      <= colour_of(mem_addr2);
    mem_rdata2 <= m2_s1;
  end

  int plots2 = 0;
  int dones2 = 0;
  always @(negedge clk) begin
    if (vga_plot2 === 1'b1) plots2++;
    if (frame_done2 === 1'b1) dones2++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st, vld, last;
    logic [14:0] addr;
    logic [8:0]  x, y;
    logic        e_plot, e_done, e_busy, e_rdy;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    logic [2:0]  e_col;
    logic [14:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input int st, vld, addr, x, y, last,
                              input int pl, ex, ey, ec, dn, bs, rd, cn);
    vec_t v;
    v.st = st[0]; v.vld = vld[0]; v.addr = addr[14:0]; v.x = x[8:0]; v.y = y[8:0];
    v.last = last[0]; v.e_plot = pl[0]; v.e_x = ex[7:0]; v.e_y = ey[6:0];
    v.e_col = ec[2:0]; v.e_done = dn[0]; v.e_busy = bs[0]; v.e_rdy = rd[0];
    v.e_cnt = cn[14:0];
    return v;
  endfunction

  vec_t tbl[$];

  task automatic drive1(input logic st, vld, input int addr, x, y, input logic last);
    start = st; in_valid = vld; in_addr = addr[14:0];
    in_x = x[8:0]; in_y = y[8:0]; in_last = last;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen_plot, seen_busy, kplots, tout;
    logic [2:0] kcol;
    logic [7:0] kx;
    int exp2;

    //      st vld adr  x   y  lst | plot x   y  col dn bs rd cnt
    // frame 1: three pixels, colours 5,6,7
    tbl.push_back(mk(1, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0,   0,  0,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1,   1,  0,  0,  1, 0,  0,  5, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 2,   2,  0,  1,  1, 1,  0,  6, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  1, 2,  0,  7, 0, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 1, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 0, 0, 3));
    // in_valid while IDLE is ignored
    tbl.push_back(mk(0, 1, 0,   3,  3,  0,  0, 0,  0,  0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 0, 0, 3));
    // frame 2: x=160 out of bounds, y=119 edge, start in DRAIN ignored
    tbl.push_back(mk(1, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3,   5,  5,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 4, 160,  0,  0,  1, 5,  5,  0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1,  10,119,  1,  0, 0,  0,  0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,   0,  0,  0,  1, 10,119, 6, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 0, 0, 2));
    // frame 3: two-cycle in_valid gap
    tbl.push_back(mk(1, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0,  20,  1,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  1, 20, 1,  5, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 2,  21,  2,  0,  0, 0,  0,  0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 7,  22,  3,  1,  1, 21, 2,  7, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  1, 22, 3,  4, 0, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 1, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 0, 0, 3));
    // frame 4: single pixel carrying in_last, bottom-right corner
    tbl.push_back(mk(1, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 5, 159,119,  1,  0, 0,  0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  1,159,119, 2, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 0, 0, 1));
    // frame 5: single pixel with y=120 and one with x bit 8 set
    tbl.push_back(mk(1, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 261,  0,  0,  0, 0,  0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1,   0,120,  1,  0, 0,  0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0,  0,  0,  0, 0,  0,  0, 0, 0, 0, 0));

    resetn = 1'b0;
    drive1(0, 0, 0, 0, 0, 0);
    start2 = 0; in_valid2 = 0; in_addr2 = '0; in_x2 = '0; in_y2 = '0; in_last2 = 0;
    key_colour = 3'd1;
    key_colour2 = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_cnt", plot_count, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive1(tbl[i].st, tbl[i].vld, tbl[i].addr, tbl[i].x, tbl[i].y, tbl[i].last);
      step();
      chk($sformatf("v%0d_plot", i), vga_plot, tbl[i].e_plot);
      chk($sformatf("v%0d_done", i), frame_done, tbl[i].e_done);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_rdy", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_cnt", i), plot_count, tbl[i].e_cnt);
      if (tbl[i].e_plot) begin
        chk($sformatf("v%0d_x", i), vga_x, tbl[i].e_x);
        chk($sformatf("v%0d_y", i), vga_y, tbl[i].e_y);
        chk($sformatf("v%0d_col", i), vga_colour, tbl[i].e_col);
      end
    end

    // reset asserted while two pixels are in flight
    drive1(1, 0, 0, 0, 0, 0); step();
    drive1(0, 1, 1, 1, 1, 0); step();
    drive1(0, 1, 2, 2, 2, 0); step();
    chk("rst_mid_pre_plot", vga_plot, 1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_plot", vga_plot, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cnt", plot_count, 0);
    chk("rst_mid_xyc", {vga_x, vga_y, vga_colour}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    seen_plot = 0; seen_busy = 0;
    repeat (6) begin
      step();
      if (vga_plot !== 1'b0) seen_plot++;
      if (busy !== 1'b0) seen_busy++;
    end
    chk("rst_post_plots", seen_plot, 0);
    chk("rst_post_busy", seen_busy, 0);
    chk("rst_post_cnt", plot_count, 0);
    drive1(0, 0, 0, 0, 0, 0);

`ifdef PIXEL_PLOT_TRANSPARENT_EN
    // key colour 0: addr 3 reads colour 0 (dropped), addr 6 reads colour 3
    key_colour = 3'd0;
    drive1(1, 0, 0, 0, 0, 0); step();
    drive1(0, 1, 3, 1, 1, 0); step();
    drive1(0, 1, 6, 2, 1, 1); step();
    drive1(0, 0, 0, 0, 0, 0);
    kplots = 0; kcol = '0; kx = '0; tout = 0;
    while (frame_done !== 1'b1 && tout < 10) begin
      step();
      tout++;
      if (vga_plot === 1'b1) begin
        kplots++; kcol = vga_colour; kx = vga_x;
      end
    end
    chk("key_done_seen", frame_done, 1);
    chk("key_plots", kplots, 1);
    chk("key_col", kcol, 3);
    chk("key_x", kx, 2);
    chk("key_cnt", plot_count, 1);
    step();
`endif

    // full 160x120 frame through the MEM_LAT=2 instance
    exp2 = 0;
    for (int i = 0; i < 19200; i++) begin
`ifdef PIXEL_PLOT_TRANSPARENT_EN
      if (colour_of(15'(i)) != key_colour2) exp2++;
`else
      exp2++;
`endif
    end
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int i = 0; i < 19200; i++) begin
      if (in_ready2 !== 1'b1) chk($sformatf("ff_rdy_%0d", i), in_ready2, 1);
      in_valid2 = 1'b1;
      in_addr2  = 15'(i);
      in_x2     = 9'(i % 160);
      in_y2     = 9'(i / 160);
      in_last2  = (i == 19199);
      step();
      if (i == 1) chk("ff_lat_noplot", vga_plot2, 0);
      if (i == 2) begin
        chk("ff_lat_plot", vga_plot2, 1);
        chk("ff_lat_x", vga_x2, 0);
        chk("ff_lat_col", vga_colour2, 5);
      end
    end
    in_valid2 = 1'b0; in_last2 = 1'b0;
    tout = 0;
    while (dones2 == 0 && tout < 20) begin
      step();
      tout++;
    end
    repeat (4) step();
    chk("ff_done_pulses", dones2, 1);
    chk("ff_plots", plots2, exp2);
    chk("ff_cnt", plot_count2, exp2);
    chk("ff_busy", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
